branch_offset_encoder: RTL and testbench

- Computes the signed word offset between a branch instruction's PC and its target address, and packs it into an ARMv8 branch immediate.
- Supports both immediate kinds: imm26 (B/BL) and imm19 (B.cond/CBZ/CBNZ).
- It is the inverse of the PC-relative branch target adder, which computes PC + signed offset. This block recovers the offset from PC and target.
- It sits beside the instruction-patching and self-check path as a 2-stage valid/ready pipeline with alignment and range checks and a saturating error counter.

---
 rtl/branch_offset_encoder.sv | 108 ++++++++++
 tb/tb_branch_offset_encoder.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_offset_encoder.sv
// branch_offset_encoder: PC-to-target word offset packed as ARMv8 imm26/imm19.
// Two-stage valid/ready pipeline with alignment/range flags and error count.
module branch_offset_encoder #(
  parameter int ADDR_W   = 64,
  parameter int ERRCNT_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [ADDR_W-1:0]   i_pc,
  input  logic [ADDR_W-1:0]   i_target,
  input  logic                i_kind,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [25:0]         o_imm,
  output logic                o_misaligned,
  output logic                o_out_of_range,
  output logic [ERRCNT_W-1:0] o_err_count
);

  logic                r_s1_valid;
  logic [ADDR_W-1:0]   r_s1_off;
  logic                r_s1_kind;
  logic                r_s2_valid;
  logic [25:0]         r_imm;
  logic                r_mis;
  logic                r_oor;
  logic [ERRCNT_W-1:0] r_err;

  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_s2_load;
  logic [ADDR_W-1:0]   w_off;
  logic [ADDR_W-28:0]  w_hi26;
  logic [ADDR_W-21:0]  w_hi19;
  logic                w_ok26;
  logic                w_ok19;
  logic                w_mis;
  logic                w_oor;
  logic [25:0]         w_imm;
  logic [ERRCNT_W-1:0] w_one;

  assign w_off      = i_target - i_pc;
  assign o_ready    = !r_s1_valid || !r_s2_valid || i_ready;
  assign w_in_fire  = i_valid && o_ready;
  assign w_out_fire = r_s2_valid && i_ready;
  assign w_s2_load  = r_s1_valid && (!r_s2_valid || i_ready);
  assign w_one      = {{(ERRCNT_W-1){1'b0}}, 1'b1};

  // In range when every bit above the field's sign bit copies it.
  assign w_hi26 = r_s1_off[ADDR_W-1:27];
  assign w_hi19 = r_s1_off[ADDR_W-1:20];
  assign w_ok26 = (&w_hi26) || !(|w_hi26);
  assign w_ok19 = (&w_hi19) || !(|w_hi19);

  always_comb begin
    w_mis = |r_s1_off[1:0];
    w_oor = r_s1_kind ? !w_ok19 : !w_ok26;
    w_imm = '0;
    if (w_mis || w_oor) begin
      w_imm = '0;
    end else if (r_s1_kind) begin
      w_imm = {{7{r_s1_off[20]}}, r_s1_off[20:2]};
    end else begin
      w_imm = r_s1_off[27:2];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_off   <= '0;
      r_s1_kind  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_imm      <= '0;
      r_mis      <= 1'b0;
      r_oor      <= 1'b0;
      r_err      <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_off   <= w_off;
        r_s1_kind  <= i_kind;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_imm      <= w_imm;
        r_mis      <= w_mis;
        r_oor      <= w_oor;
      end else if (w_out_fire) begin
        r_s2_valid <= 1'b0;
      end
      if (w_out_fire && (r_mis || r_oor) && !(&r_err)) begin
        r_err <= r_err + w_one;
      end
    end
  end

  assign o_valid        = r_s2_valid;
  assign o_imm          = r_imm;
  assign o_misaligned   = r_mis;
  assign o_out_of_range = r_oor;
  assign o_err_count    = r_err;

endmodule

// File: tb/tb_branch_offset_encoder.sv
// tb_branch_offset_encoder: directed and randomized checks of the
// branch offset encoder against an arithmetic reference model.
module tb_branch_offset_encoder;

  typedef struct packed {
    logic        mis;
    logic        oor;
    logic [25:0] imm;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic        kind;
  logic [63:0] pc;
  logic [63:0] tgt;

  logic        m_ready, m_valid, m_mis, m_oor;
  logic [25:0] m_imm;
  logic [15:0] m_err;
  logic        s_ready, s_valid, s_mis, s_oor;
  logic [25:0] s_imm;
  logic [3:0]  s_err;

  int n_tests = 0;
  int n_fail  = 0;
  int flagged = 0;

  always #5 clk = ~clk;

  branch_offset_encoder u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (valid),
    .o_ready        (m_ready),
    .i_pc           (pc),
    .i_target       (tgt),
    .i_kind         (kind),
    .o_valid        (m_valid),
    .i_ready        (ready),
    .o_imm          (m_imm),
    .o_misaligned   (m_mis),
    .o_out_of_range (m_oor),
    .o_err_count    (m_err)
  );

  branch_offset_encoder #(
    .ADDR_W   (64),
    .ERRCNT_W (4)
  ) u_sat (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (valid),
    .o_ready        (s_ready),
    .i_pc           (pc),
    .i_target       (tgt),
    .i_kind         (kind),
    .o_valid        (s_valid),
    .i_ready        (ready),
    .o_imm          (s_imm),
    .o_misaligned   (s_mis),
    .o_out_of_range (s_oor),
    .o_err_count    (s_err)
  );

  function automatic res_t model(logic [63:0] p, logic [63:0] t,
                                 logic k);
    res_t   r;
    longint off;
    longint lim;
    longint w;
    off   = longint'(t - p);
    lim   = k ? (longint'(1) <<< 20) : (longint'(1) <<< 27);
    r.mis = (off & longint'(3)) != 0;
    r.oor = (off < -lim) || (off >= lim);
    w     = off / 4;
    r.imm = (r.mis || r.oor) ? 26'd0 : w[25:0];
    return r;
  endfunction

  function automatic logic [15:0] exp16();
    int f;
    f = flagged;
    return (f > 65535) ? 16'hFFFF : f[15:0];
  endfunction

  function automatic logic [3:0] exp4();
    int f;
    f = flagged;
    return (f > 15) ? 4'hF : f[3:0];
  endfunction

  task automatic gen(output logic [63:0] p, output logic [63:0] t,
                     output logic k);
    longint off;
    int     x;
    int     sel;
    p   = {$urandom, $urandom};
    k   = 1'($urandom_range(0, 1));
    sel = int'($urandom_range(0, 5));
    x   = int'($urandom);
    case (sel)
      0: off = (longint'($urandom_range(0, 8191)) - 4096) * 4;
      1: off = ($urandom_range(0, 1) != 0 ? (longint'(1) <<< 20)
                : -(longint'(1) <<< 20))
               + longint'($urandom_range(0, 16)) - 8;
      2: off = ($urandom_range(0, 1) != 0 ? (longint'(1) <<< 27)
                : -(longint'(1) <<< 27))
               + longint'($urandom_range(0, 16)) - 8;
      3: off = longint'({$urandom, $urandom});
      4: off = ((longint'(x) <<< 36) >>> 36) & ~longint'(3);
      default: off = (longint'($urandom_range(0, 8191)) - 4096) * 4
                     + longint'($urandom_range(1, 3));
    endcase
    t = p + 64'(off);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b0;
    ready = 1'b0;
    pc    = '0;
    tgt   = '0;
    kind  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    flagged = 0;
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b expected 0", m_valid);
    end
    n_tests++;
    if ({m_mis, m_oor, m_imm} !== 28'd0) begin
      n_fail++;
      $display("FAIL rst_out: got %h expected 0", {m_mis, m_oor, m_imm});
    end
    n_tests++;
    if (m_err !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_err: got %h expected 0", m_err);
    end
    n_tests++;
    if (m_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b expected 1", m_ready);
    end
  endtask

  task automatic test_directed();
    logic [63:0] d_pc [9] = '{64'h1000, 64'h1000, 64'h0, 64'h0,
                              64'h1000, 64'h1000, 64'hFFFFFFFFFFFFFFF8,
                              64'h8000000, 64'h0};
    logic [63:0] d_tg [9] = '{64'h1010, 64'h0FFC, 64'hFFFFC, 64'h100000,
                              64'h8000FFC, 64'h8001000, 64'h2,
                              64'h0, 64'h100002};
    logic        d_k  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b1};
    res_t        d_e  [9] = '{{2'b00, 26'h0000004}, {2'b00, 26'h3FFFFFF},
                              {2'b00, 26'h003FFFF}, {2'b01, 26'h0},
                              {2'b00, 26'h1FFFFFF}, {2'b01, 26'h0},
                              {2'b10, 26'h0}, {2'b00, 26'h2000000},
                              {2'b11, 26'h0}};
    res_t e;
    for (int i = 0; i < 9; i++) begin
      e = d_e[i];
      @(posedge clk);
      #1;
      ready = 1'b1;
      valid = 1'b1;
      pc    = d_pc[i];
      tgt   = d_tg[i];
      kind  = d_k[i];
      #2;
      n_tests++;
      if (m_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dir%0d_ready: got %b expected 1", i, m_ready);
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
      pc    = {$urandom, $urandom};
      tgt   = {$urandom, $urandom};
      kind  = 1'($urandom_range(0, 1));
      #2;
      n_tests++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_early: got valid %b expected 0",
                 i, m_valid);
      end
      @(posedge clk);
      #3;
      n_tests++;
      if ({m_valid, m_mis, m_oor, m_imm} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL dir%0d_result: got %h expected %h", i,
                 {m_valid, m_mis, m_oor, m_imm}, {1'b1, e});
      end
      if (e.mis || e.oor) flagged++;
      @(posedge clk);
      #3;
      n_tests++;
      if ({m_valid, m_err} !== {1'b0, exp16()}) begin
        n_fail++;
        $display("FAIL dir%0d_err: got v=%b cnt=%0d expected v=0 cnt=%0d",
                 i, m_valid, m_err, exp16());
      end
    end
  endtask

  task automatic test_backpressure();
    res_t        q [$];
    res_t        e;
    logic [63:0] p [5];
    logic [63:0] t [5];
    logic        k [5];
    int          sent  = 0;
    int          got   = 0;
    int          stall = 4;
    int          cyc   = 0;
    logic        hv    = 1'b0;
    logic [28:0] held  = '0;
    logic        low   = 1'b0;
    for (int i = 0; i < 5; i++) gen(p[i], t[i], k[i]);
    while (got < 5 && cyc < 60) begin
      @(posedge clk);
      #1;
      valid = (sent < 5);
      if (sent < 5) begin
        pc   = p[sent];
        tgt  = t[sent];
        kind = k[sent];
      end
      ready = !(got >= 1 && stall > 0);
      #2;
      n_tests++;
      if (m_err !== exp16()) begin
        n_fail++;
        $display("FAIL bp_err: got %0d expected %0d", m_err, exp16());
      end
      if (hv) begin
        n_tests++;
        if ({m_valid, m_mis, m_oor, m_imm} !== held) begin
          n_fail++;
          $display("FAIL bp_hold: got %h expected %h",
                   {m_valid, m_mis, m_oor, m_imm}, held);
        end
      end
      n_tests++;
      if (m_ready !== ((sent - got < 2) || ready)) begin
        n_fail++;
        $display("FAIL bp_ready: got %b expected %b", m_ready,
                 (sent - got < 2) || ready);
      end
      if (!m_ready) low = 1'b1;
      if (stall == 0) begin
        n_tests++;
        if (m_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_thru: got valid %b expected 1", m_valid);
        end
      end
      if (m_valid && ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: got unexpected result expected none");
        end else begin
          e = q.pop_front();
          if ({m_mis, m_oor, m_imm} !== e) begin
            n_fail++;
            $display("FAIL bp_res%0d: got %h expected %h", got,
                     {m_mis, m_oor, m_imm}, e);
          end
          if (e.mis || e.oor) flagged++;
        end
        got++;
      end
      hv   = m_valid && !ready;
      held = {m_valid, m_mis, m_oor, m_imm};
      if (valid && m_ready) begin
        q.push_back(model(p[sent], t[sent], k[sent]));
        sent++;
      end
      if (!ready && stall > 0) stall--;
      cyc++;
    end
    valid = 1'b0;
    ready = 1'b1;
    n_tests++;
    if (got != 5) begin
      n_fail++;
      $display("FAIL bp_timeout: got %0d results expected 5", got);
    end
    n_tests++;
    if (low !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_readylow: got %b expected 1", low);
    end
  endtask

  task automatic test_random();
    res_t        q [$];
    res_t        e;
    logic [63:0] p;
    logic [63:0] t;
    logic        k;
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    logic        have = 1'b0;
    logic        hv   = 1'b0;
    logic [28:0] held = '0;
    while (got < 300 && cyc < 6000) begin
      @(posedge clk);
      #1;
      if (!have && sent < 300) begin
        gen(p, t, k);
        have = 1'b1;
      end
      valid = have && ($urandom_range(0, 3) != 0);
      if (valid) begin
        pc   = p;
        tgt  = t;
        kind = k;
      end else begin
        pc   = {$urandom, $urandom};
        tgt  = {$urandom, $urandom};
        kind = 1'($urandom_range(0, 1));
      end
      ready = ($urandom_range(0, 3) != 0);
      #2;
      n_tests++;
      if (m_err !== exp16()) begin
        n_fail++;
        $display("FAIL rnd_err: got %0d expected %0d", m_err, exp16());
      end
      if (hv) begin
        n_tests++;
        if ({m_valid, m_mis, m_oor, m_imm} !== held) begin
          n_fail++;
          $display("FAIL rnd_hold: got %h expected %h",
                   {m_valid, m_mis, m_oor, m_imm}, held);
        end
      end
      n_tests++;
      if (m_ready !== ((sent - got < 2) || ready)) begin
        n_fail++;
        $display("FAIL rnd_ready: got %b expected %b", m_ready,
                 (sent - got < 2) || ready);
      end
      if (m_valid && ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra: got unexpected result expected none");
        end else begin
          e = q.pop_front();
          if ({m_mis, m_oor, m_imm} !== e) begin
            n_fail++;
            $display("FAIL rnd_res%0d: got %h expected %h", got,
                     {m_mis, m_oor, m_imm}, e);
          end
          if (e.mis || e.oor) flagged++;
        end
        got++;
      end
      hv   = m_valid && !ready;
      held = {m_valid, m_mis, m_oor, m_imm};
      if (valid && m_ready) begin
        q.push_back(model(p, t, k));
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    valid = 1'b0;
    ready = 1'b1;
    n_tests++;
    if (got != 300) begin
      n_fail++;
      $display("FAIL rnd_timeout: got %0d results expected 300", got);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    ready = 1'b0;
    valid = 1'b1;
    pc    = 64'h4000;
    tgt   = 64'h4001;
    kind  = 1'b0;
    @(posedge clk);
    #1;
    pc    = 64'h0;
    tgt   = 64'h200000;
    kind  = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ready = 1'b1;
    #2;
    flagged = 0;
    n_tests++;
    if ({m_valid, m_err} !== 17'd0) begin
      n_fail++;
      $display("FAIL rmid_state: got v=%b cnt=%0d expected v=0 cnt=0",
               m_valid, m_err);
    end
    n_tests++;
    if (m_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_ready: got %b expected 1", m_ready);
    end
    n_tests++;
    if (s_err !== 4'd0) begin
      n_fail++;
      $display("FAIL rmid_saterr: got %0d expected 0", s_err);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #3;
      n_tests++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_stale%0d: got valid %b expected 0",
                 i, m_valid);
      end
    end
  endtask

  task automatic test_saturation();
    res_t        q [$];
    res_t        e;
    logic [63:0] p;
    logic [63:0] t;
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    ready = 1'b1;
    while (got < 20 && cyc < 100) begin
      @(posedge clk);
      #1;
      p     = {$urandom, $urandom};
      t     = p + 64'(4 * $urandom_range(0, 100) + 1);
      valid = (sent < 20);
      pc    = p;
      tgt   = t;
      kind  = 1'($urandom_range(0, 1));
      #2;
      n_tests++;
      if ({m_err, s_err} !== {exp16(), exp4()}) begin
        n_fail++;
        $display("FAIL sat_cnt: got %0d/%0d expected %0d/%0d",
                 m_err, s_err, exp16(), exp4());
      end
      n_tests++;
      if ({m_ready, s_ready} !== 2'b11) begin
        n_fail++;
        $display("FAIL sat_ready: got %b expected 11", {m_ready, s_ready});
      end
      if (m_valid) begin
        n_tests++;
        e = (q.size() != 0) ? q.pop_front() : '1;
        if ({m_mis, m_oor, m_imm, s_valid, s_mis, s_oor, s_imm} !==
            {e, 1'b1, e}) begin
          n_fail++;
          $display("FAIL sat_res%0d: got %h/%h expected %h", got,
                   {m_mis, m_oor, m_imm}, {s_mis, s_oor, s_imm}, e);
        end
        if (e.mis || e.oor) flagged++;
        got++;
      end
      if (valid && m_ready) begin
        q.push_back(model(p, t, kind));
        sent++;
      end
      cyc++;
    end
    valid = 1'b0;
    @(posedge clk);
    #3;
    n_tests++;
    if (s_err !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_hold: got %h expected f", s_err);
    end
    n_tests++;
    if (m_err !== 16'd20) begin
      n_fail++;
      $display("FAIL sat_main: got %0d expected 20", m_err);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
